// File: rtl/result_bcd_converter.sv
// Converts a multiplier product into sign + packed BCD digits with an
// iterative shift-add-3 (double-dabble) sequence, one bit per clock.
module result_bcd_converter #(
  parameter int WORD_LENGTH = 5,
  parameter int DIGITS      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       op,
  input  logic [2*WORD_LENGTH-1:0]   Result,
  output logic                       busy,
  output logic                       done,
  output logic                       sign,
  output logic [4*DIGITS-1:0]        BCD
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(PW + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [CW-1:0] LAST_ITER = CW'(PW - 1);

  logic [1:0]    state;
  logic [PW-1:0] mag;
  logic [PW-1:0] mag_next;
  logic [PW-1:0] start_mag;
  logic          start_neg;
  logic [BW-1:0] bcd_work;
  logic [BW-1:0] bcd_adj;
  logic [BW-1:0] bcd_next;
  logic [CW-1:0] count;
  logic          sign_r;

  // Zero-extended negation, so the most negative product keeps its full magnitude.
  assign start_neg = op && Result[PW-1];
  assign start_mag = start_neg ? (~Result + PW'(1)) : Result;

  // NOTE: every variable written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_work[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
      end
    end
    {bcd_next, mag_next} = {bcd_adj, mag} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      BCD      <= '0;
      mag      <= '0;
      bcd_work <= '0;
      count    <= '0;
      sign_r   <= 1'b0;
    end else begin
      case (state)
        // DONE returns to IDLE on its exit edge; a start seen on that same
        // edge is taken directly, giving one conversion per PW+1 cycles.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mag      <= start_mag;
            sign_r   <= start_neg;
            bcd_work <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end

        CONVERT: begin
          mag      <= mag_next;
          bcd_work <= bcd_next;
          count    <= count + CW'(1);
          if (count == LAST_ITER) begin
            BCD   <= bcd_next;
            sign  <= sign_r;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: an arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_result_bcd_converter;

  localparam int WL     = 5;
  localparam int DIGITS = 4;
  localparam int PW     = 2 * WL;
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          op;
  logic [PW-1:0] Result;
  logic          busy;
  logic          done;
  logic          sign;
  logic [BW-1:0] BCD;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  result_bcd_converter #(.WORD_LENGTH(WL), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .Result (Result),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .BCD    (BCD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference model: a conversion takes PW cycles after acceptance; start is
  // accepted whenever no conversion is running (idle or the done cycle).
  int            m_left;
  bit            m_busy, m_done, m_sign, p_sign;
  logic [BW-1:0] m_bcd, p_bcd;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_busy = 0; m_done = 0; m_sign = 0; m_bcd = '0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_sign = p_sign; m_bcd = p_bcd;
      end
    end else begin
      m_done = 0;
      if (start) begin
        int v;
        v = int'(Result);
        if (op && v >= (1 << (PW - 1))) begin
          p_sign = 1; p_bcd = to_bcd((1 << PW) - v);
        end else begin
          p_sign = 0; p_bcd = to_bcd(v);
        end
        m_busy = 1; m_left = PW;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_sign", 32'(sign), 32'(m_sign));
      check("model_bcd",  32'(BCD),  32'(m_bcd));
    end
  end

  // Pulse start, then wait (bounded) for done; check latency, busy span and literals.
  task automatic run(input bit o, input logic [PW-1:0] r, input bit es, input logic [BW-1:0] eb);
    int k, busy_cycles;
    @(negedge clk);
    op = o; Result = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; busy_cycles = 0;
    while (!done && k < 30) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      k++;
    end
    check("latency",   32'(k - 1), 32'd10);
    check("busy_span", 32'(busy_cycles), 32'd10);
    check("lit_sign",  32'(sign), 32'(es));
    check("lit_bcd",   32'(BCD),  32'(eb));
  endtask

  initial begin
    int dones, k;
    reset = 1'b1; start = 1'b0; op = 1'b0; Result = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_bcd",  32'(BCD),  32'd0);

    run(1'b1, 10'h371, 1'b1, 16'h0143);
    run(1'b0, 10'h371, 1'b0, 16'h0881);
    run(1'b1, 10'h200, 1'b1, 16'h0512);
    run(1'b0, 10'h3FF, 1'b0, 16'h1023);
    run(1'b1, 10'h3FF, 1'b1, 16'h0001);
    run(1'b1, 10'h000, 1'b0, 16'h0000);
    run(1'b0, 10'h200, 1'b0, 16'h0512);

    // Second start three cycles into a conversion must be ignored.
    @(negedge clk);
    op = 1'b1; Result = 10'h371; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) begin op = 1'b0; Result = 10'h005; start = 1'b1; end
      else start = 1'b0;
      if (i == 5) begin op = 1'b0; Result = 10'h3FF; end
      if (done) dones++;
      @(negedge clk);
    end
    check("ignore_dones", 32'(dones), 32'd1);
    check("ignore_sign",  32'(sign), 32'd1);
    check("ignore_bcd",   32'(BCD),  32'h0143);

    // Reset five cycles into a conversion abandons it.
    op = 1'b0; Result = 10'h3FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sign", 32'(sign), 32'd0);
    check("midrst_bcd",  32'(BCD),  32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run(1'b1, 10'h3FF, 1'b1, 16'h0001);

    // Back-to-back: start during the done cycle is accepted.
    run(1'b0, 10'h07B, 1'b0, 16'h0123);
    op = 1'b1; Result = 10'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("b2b_gap",  32'(k), 32'd11);
    check("b2b_sign", 32'(sign), 32'd1);
    check("b2b_bcd",  32'(BCD),  32'h0512);

    // Start held high: conversions repeat every 11 cycles.
    op = 1'b0; Result = 10'h0FF; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    check("held_dones", 32'(dones), 32'd3);
    check("held_bcd",   32'(BCD),  32'h0255);
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
